// File: rtl/sram_ctrl_if.sv
// sram_ctrl_if -- host-side request/response bundle for the SRAM access sequencer.
//   master : req, we, addr, wdata driven by the host; ready, done, err, rdata observed.
//   slave  : the controller side of the same signals.
interface sram_ctrl_if #(
  parameter int ADDR_W = 3,
  parameter int COLS   = 8
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [COLS-1:0]   wdata;
  logic              ready;
  logic              done;
  logic              err;
  logic [COLS-1:0]   rdata;

  modport master (
    output req, we, addr, wdata,
    input  ready, done, err, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output ready, done, err, rdata
  );
endinterface

// File: rtl/sram_ctrl.sv
// sram_ctrl -- single-port access sequencer for the mixed-signal SRAM macro.
// Takes one read or write at a time and walks the analog control levels through
// precharge -> wordline -> sense-amp (read) or write-driver (write), then pulses done.
//
// Ports:
//   clk      : clock, rising edge
//   rst      : asynchronous reset, active high
//   bus      : host handshake (req/we/addr/wdata in, ready/done/err/rdata out)
//   sa_out   : sense-amp output levels, one per bitline pair
//   rd_wr    : precharge enable level
//   wl       : wordline levels
//   sae      : sense-amp enable level
//   wr_en    : write-driver enable level
//   din_drv  : write-driver data levels
module sram_ctrl #(
  parameter int ROWS    = 8,
  parameter int COLS    = 8,
  parameter int ADDR_W  = 3,
  parameter int PRE_CYC = 2,
  parameter int SA_CYC  = 1,
  parameter int WR_CYC  = 2
) (
  input  logic       clk,
  input  logic       rst,
  sram_ctrl_if.slave bus,
  input  real        sa_out  [0:COLS-1],
  output real        rd_wr,
  output real        wl      [0:ROWS-1],
  output real        sae,
  output real        wr_en,
  output real        din_drv [0:COLS-1]
);

  localparam real VDD = 1.5;
  localparam real VSS = 0.0;
  localparam real VTH = 0.8;

  localparam int MAX_AB  = (PRE_CYC > SA_CYC) ? PRE_CYC : SA_CYC;
  localparam int MAX_CYC = (MAX_AB > WR_CYC) ? MAX_AB : WR_CYC;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CNT_W-1:0] PRE_LD = CNT_W'(PRE_CYC - 1);
  localparam logic [CNT_W-1:0] SA_LD  = CNT_W'(SA_CYC - 1);
  localparam logic [CNT_W-1:0] WR_LD  = CNT_W'(WR_CYC - 1);
  localparam logic [ADDR_W:0]  ROWS_LIM = (ADDR_W + 1)'(ROWS);

  typedef enum logic [2:0] {
    IDLE,
    PRECH,
    WLON,
    SENSE,
    WRITE,
    DONE
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              we_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [COLS-1:0]   wdata_reg;

  // Registered digital images of every output; the real levels are pure decodes.
  logic              ready_reg;
  logic              done_reg;
  logic              err_reg;
  logic [COLS-1:0]   rdata_reg;
  logic              rd_wr_reg;
  logic [ROWS-1:0]   wl_reg;
  logic              sae_reg;
  logic              wr_en_reg;
  logic [COLS-1:0]   din_reg;

  logic [ROWS-1:0]   wl_sel;
  logic [COLS-1:0]   sa_bit;
  logic              addr_oor;

  // One-hot row select from the latched address; an out-of-range address
  // matches no row, so no wordline is ever raised for it.
  generate
    for (genvar gi = 0; gi < ROWS; gi++) begin : g_wl_sel
      assign wl_sel[gi] = (addr_reg == ADDR_W'(gi));
    end
  endgenerate

  assign addr_oor = ({1'b0, addr_reg} >= ROWS_LIM);

  // Digitise sense-amp levels against the threshold.
  generate
    for (genvar gi = 0; gi < COLS; gi++) begin : g_sa_bit
      assign sa_bit[gi] = (sa_out[gi] >= VTH);
    end
  endgenerate

  // Single sequencing process. Outputs are assigned on the edge that enters
  // the state they belong to, so they are valid for exactly that state's cycles.
  // rd_wr is dropped on the same edge the wordline rises (break-before-make).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      we_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      ready_reg <= 1'b1;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
      rdata_reg <= '0;
      rd_wr_reg <= 1'b0;
      wl_reg    <= '0;
      sae_reg   <= 1'b0;
      wr_en_reg <= 1'b0;
      din_reg   <= '0;
    end else begin
      done_reg <= 1'b0;
      err_reg  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req && ready_reg) begin
            we_reg    <= bus.we;
            addr_reg  <= bus.addr;
            wdata_reg <= bus.wdata;
            ready_reg <= 1'b0;
            rd_wr_reg <= 1'b1;
            wl_reg    <= '0;
            cnt       <= PRE_LD;
            state     <= PRECH;
          end
        end
        PRECH: begin
          if (cnt == '0) begin
            rd_wr_reg <= 1'b0;
            wl_reg    <= wl_sel;
            if (we_reg) begin
              wr_en_reg <= 1'b1;
              din_reg   <= wdata_reg;
              cnt       <= WR_LD;
              state     <= WRITE;
            end else begin
              state <= WLON;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        WLON: begin
          sae_reg <= 1'b1;
          cnt     <= SA_LD;
          state   <= SENSE;
        end
        SENSE: begin
          if (cnt == '0) begin
            if (!addr_oor) begin
              rdata_reg <= sa_bit;
            end
            wl_reg   <= '0;
            sae_reg  <= 1'b0;
            done_reg <= 1'b1;
            err_reg  <= addr_oor;
            state    <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        WRITE: begin
          if (cnt == '0) begin
            wl_reg    <= '0;
            wr_en_reg <= 1'b0;
            din_reg   <= '0;
            done_reg  <= 1'b1;
            err_reg   <= addr_oor;
            state     <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          ready_reg <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          ready_reg <= 1'b1;
          rd_wr_reg <= 1'b0;
          wl_reg    <= '0;
          sae_reg   <= 1'b0;
          wr_en_reg <= 1'b0;
          din_reg   <= '0;
          state     <= IDLE;
        end
      endcase
    end
  end

  assign bus.ready = ready_reg;
  assign bus.done  = done_reg;
  assign bus.err   = err_reg;
  assign bus.rdata = rdata_reg;

  assign rd_wr = rd_wr_reg ? VDD : VSS;
  assign sae   = sae_reg   ? VDD : VSS;
  assign wr_en = wr_en_reg ? VDD : VSS;

  generate
    for (genvar gi = 0; gi < ROWS; gi++) begin : g_wl_out
      assign wl[gi] = wl_reg[gi] ? VDD : VSS;
    end
    for (genvar gi = 0; gi < COLS; gi++) begin : g_din_out
      assign din_drv[gi] = din_reg[gi] ? VDD : VSS;
    end
  endgenerate

endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl -- randomized self-checking bench for sram_ctrl.
// Two instances: dut0 with default parameters, dut1 with ROWS=6, PRE_CYC=1,
// SA_CYC=3 (out-of-range addresses and a different timing set).
// The reference model derives the expected per-cycle levels from the access
// timing rules (cycle offsets after the acceptance edge).
module tb_sram_ctrl;

  logic clk;
  logic rst;
  logic req;
  logic we;
  logic [2:0] addr;
  logic [7:0] wdata;
  int sel;

  real sa_out [0:7];
  real rd_wr0, sae0, wr_en0;
  real wl0 [0:7];
  real din0 [0:7];
  real rd_wr1, sae1, wr_en1;
  real wl1 [0:5];
  real din1 [0:7];

  int n_checks;
  int n_errors;
  int rd_model [0:1];

  sram_ctrl_if #(.ADDR_W(3), .COLS(8)) if0 ();
  sram_ctrl_if #(.ADDR_W(3), .COLS(8)) if1 ();

  assign if0.req   = req & (sel == 0);
  assign if0.we    = we;
  assign if0.addr  = addr;
  assign if0.wdata = wdata;
  assign if1.req   = req & (sel == 1);
  assign if1.we    = we;
  assign if1.addr  = addr;
  assign if1.wdata = wdata;

  sram_ctrl #(.ROWS(8), .COLS(8), .ADDR_W(3), .PRE_CYC(2), .SA_CYC(1), .WR_CYC(2)) dut0 (
    .clk(clk), .rst(rst), .bus(if0), .sa_out(sa_out),
    .rd_wr(rd_wr0), .wl(wl0), .sae(sae0), .wr_en(wr_en0), .din_drv(din0)
  );

  sram_ctrl #(.ROWS(6), .COLS(8), .ADDR_W(3), .PRE_CYC(1), .SA_CYC(3), .WR_CYC(2)) dut1 (
    .clk(clk), .rst(rst), .bus(if1), .sa_out(sa_out),
    .rd_wr(rd_wr1), .wl(wl1), .sae(sae1), .wr_en(wr_en1), .din_drv(din1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int lv(input real x);
    if (x == 1.5) return 1;
    if (x == 0.0) return 0;
    return 2;
  endfunction

  task automatic get_obs(output int rdw, output int sa, output int wre, output int wlm,
                         output int dinm, output int bad, output int rdy, output int dn,
                         output int er, output int rdat);
    wlm = 0; dinm = 0; bad = 0;
    if (sel == 0) begin
      rdw = lv(rd_wr0); sa = lv(sae0); wre = lv(wr_en0);
      for (int i = 0; i < 8; i++) begin
        if (lv(wl0[i]) == 1) wlm |= (1 << i);
        if (lv(wl0[i]) == 2) bad++;
        if (lv(din0[i]) == 1) dinm |= (1 << i);
        if (lv(din0[i]) == 2) bad++;
      end
      rdy = int'(if0.ready); dn = int'(if0.done); er = int'(if0.err); rdat = int'(if0.rdata);
    end else begin
      rdw = lv(rd_wr1); sa = lv(sae1); wre = lv(wr_en1);
      for (int i = 0; i < 6; i++) begin
        if (lv(wl1[i]) == 1) wlm |= (1 << i);
        if (lv(wl1[i]) == 2) bad++;
      end
      for (int i = 0; i < 8; i++) begin
        if (lv(din1[i]) == 1) dinm |= (1 << i);
        if (lv(din1[i]) == 2) bad++;
      end
      rdy = int'(if1.ready); dn = int'(if1.done); er = int'(if1.err); rdat = int'(if1.rdata);
    end
  endtask

  function automatic int sa_bits();
    int b;
    b = 0;
    for (int i = 0; i < 8; i++) if (sa_out[i] >= 0.8) b |= (1 << i);
    return b;
  endfunction

  task automatic rand_sa();
    real lvls [0:5];
    lvls[0] = 0.0; lvls[1] = 0.5; lvls[2] = 0.79; lvls[3] = 0.8; lvls[4] = 1.2; lvls[5] = 1.5;
    for (int i = 0; i < 8; i++) sa_out[i] = lvls[$urandom_range(0, 5)];
  endtask

  // One complete access on instance s, checked every cycle from the
  // acceptance edge (k=0) through the cycle after done (k=lat+1).
  task automatic do_op(input int s, input bit w, input logic [2:0] a, input logic [7:0] d);
    int pre, sac, wrc, rows, lat, sab, e_wl_on, e_wlm, e_din, e_sae, e_wre;
    int rdw, sa, wre, wlm, dinm, bad, rdy, dn, er, rdat, tmo;
    bit ok;
    string t;
    sel  = s;
    pre  = (s == 1) ? 1 : 2;
    sac  = (s == 1) ? 3 : 1;
    wrc  = 2;
    rows = (s == 1) ? 6 : 8;
    ok   = (int'(a) < rows);
    lat  = w ? (pre + wrc) : (pre + 1 + sac);
    sab  = sa_bits();
    @(negedge clk);
    get_obs(rdw, sa, wre, wlm, dinm, bad, rdy, dn, er, rdat);
    tmo = 0;
    while (rdy == 0 && tmo < 20) begin
      @(negedge clk);
      get_obs(rdw, sa, wre, wlm, dinm, bad, rdy, dn, er, rdat);
      tmo++;
    end
    if (rdy == 0) begin
      check_eq("ready_timeout", rdy, 1);
      return;
    end
    we = w; addr = a; wdata = d; req = 1'b1;
    @(posedge clk);
    for (int k = 0; k <= lat + 1; k++) begin
      @(negedge clk);
      if (k == 0) req = 1'b0;
      if (k == lat && !w && ok) rd_model[s] = sab;
      e_wl_on = (k >= pre && k < lat) ? 1 : 0;
      e_wlm   = (e_wl_on != 0 && ok) ? (1 << a) : 0;
      e_sae   = (!w && k > pre && k < lat) ? 1 : 0;
      e_wre   = (w && e_wl_on != 0) ? 1 : 0;
      e_din   = (e_wre != 0) ? int'(d) : 0;
      get_obs(rdw, sa, wre, wlm, dinm, bad, rdy, dn, er, rdat);
      t = $sformatf("d%0d k%0d", s, k);
      check_eq({t, " rd_wr"}, rdw, (k < pre) ? 1 : 0);
      check_eq({t, " wl"}, wlm, e_wlm);
      check_eq({t, " sae"}, sa, e_sae);
      check_eq({t, " wr_en"}, wre, e_wre);
      check_eq({t, " din_drv"}, dinm, e_din);
      check_eq({t, " levels"}, bad, 0);
      check_eq({t, " done"}, dn, (k == lat) ? 1 : 0);
      check_eq({t, " err"}, er, (k == lat && !ok) ? 1 : 0);
      check_eq({t, " ready"}, rdy, (k == lat + 1) ? 1 : 0);
      check_eq({t, " rdata"}, rdat, rd_model[s]);
      check_eq({t, " bbm"}, (wlm != 0 && rdw == 1) ? 1 : 0, 0);
    end
    $display("TXN dut%0d %s addr=%0d wdata=%02h rdata=%02h lat=%0d", s, w ? "WR" : "RD",
             a, d, rdat, lat);
  endtask

  initial begin
    int rdw, sa, wre, wlm, dinm, bad, rdy, dn, er, rdat, lat, n_done, d1, d2, s;
    n_checks = 0;
    n_errors = 0;
    rd_model[0] = 0;
    rd_model[1] = 0;
    rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; sel = 0;
    for (int i = 0; i < 8; i++) sa_out[i] = 0.0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int j = 0; j < 2; j++) begin
      sel = j;
      get_obs(rdw, sa, wre, wlm, dinm, bad, rdy, dn, er, rdat);
      check_eq($sformatf("rst d%0d ready", j), rdy, 1);
      check_eq($sformatf("rst d%0d done", j), dn, 0);
      check_eq($sformatf("rst d%0d rdata", j), rdat, 0);
      check_eq($sformatf("rst d%0d analog", j), rdw + sa + wre + wlm + dinm + bad, 0);
    end
    $display("TXN reset idle");

    // Directed read from the plan: addr 5, expected rdata 8'b11000101.
    sa_out[0] = 1.5; sa_out[1] = 0.0; sa_out[2] = 1.5; sa_out[3] = 0.0;
    sa_out[4] = 0.0; sa_out[5] = 0.0; sa_out[6] = 1.5; sa_out[7] = 1.2;
    do_op(0, 1'b0, 3'd5, 8'h00);
    check_eq("dir read rdata", int'(if0.rdata), 8'hC5);
    do_op(0, 1'b1, 3'd2, 8'hA5);
    check_eq("dir write keeps rdata", int'(if0.rdata), 8'hC5);
    do_op(1, 1'b0, 3'd7, 8'h00);
    do_op(1, 1'b0, 3'd3, 8'h00);
    do_op(1, 1'b1, 3'd6, 8'h3C);

    // Busy rejection: req held high across two reads on dut0.
    sel = 0;
    rand_sa();
    lat = 4; n_done = 0; d1 = -1; d2 = -1;
    @(negedge clk);
    we = 1'b0; addr = 3'd1; req = 1'b1;
    @(posedge clk);
    for (int k = 0; k <= 2 * lat + 4; k++) begin
      @(negedge clk);
      get_obs(rdw, sa, wre, wlm, dinm, bad, rdy, dn, er, rdat);
      if (dn == 1) begin
        n_done++;
        if (d1 < 0) d1 = k; else d2 = k;
      end
      if (k == lat + 2) begin
        check_eq("busy reaccept rd_wr", rdw, 1);
        req = 1'b0;
      end
    end
    rd_model[0] = sa_bits();
    check_eq("busy done count", n_done, 2);
    check_eq("busy first done", d1, lat);
    check_eq("busy second done", d2, 2 * lat + 2);
    check_eq("busy rdata", int'(if0.rdata), rd_model[0]);
    $display("TXN busy hold two reads done at %0d and %0d", d1, d2);

    // Reset in the middle of SENSE.
    rand_sa();
    sel = 0;
    @(negedge clk);
    we = 1'b0; addr = 3'd4; req = 1'b1;
    @(posedge clk);
    for (int k = 0; k <= 3; k++) begin
      @(negedge clk);
      if (k == 0) req = 1'b0;
    end
    get_obs(rdw, sa, wre, wlm, dinm, bad, rdy, dn, er, rdat);
    check_eq("pre-rst sae", sa, 1);
    rst = 1'b1;
    #1;
    get_obs(rdw, sa, wre, wlm, dinm, bad, rdy, dn, er, rdat);
    check_eq("midrst analog", rdw + sa + wre + wlm + dinm + bad, 0);
    check_eq("midrst ready", rdy, 1);
    check_eq("midrst rdata", rdat, 0);
    rd_model[0] = 0;
    rd_model[1] = 0;
    @(negedge clk);
    rst = 1'b0;
    n_done = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (if0.done) n_done++;
    end
    check_eq("midrst no done", n_done, 0);
    $display("TXN reset during sense");

    // Randomized accesses on both instances.
    for (int n = 0; n < 40; n++) begin
      rand_sa();
      s = int'($urandom_range(0, 1));
      do_op(s, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sram_ctrl.md
Name: sram_ctrl

Overview:
- Single-port access sequencer for the mixed-signal SRAM macro.
- Accepts one read or write request at a time over a ready/valid-style handshake.
- Sequences the analog-domain control levels in a fixed order: bitline precharge (rd_wr), wordline select, then sense-amp enable (read) or write-driver enable (write).
- Digitises sense-amp outputs into rdata. Sits between the digital host logic and the precharge, wordline, sense-amp and write-driver blocks.

Parameters:
ROWS, 8, number of wordlines
COLS, 8, number of bitline pairs / data width
ADDR_W, 3, row address width (2**ADDR_W >= ROWS)
PRE_CYC, 2, precharge duration in clk cycles (>=1)
SA_CYC, 1, sense-amp enable duration in cycles (>=1)
WR_CYC, 2, write-drive duration in cycles (>=1)

Ports:
clk  input  1  clock, rising edge active
rst  input  1  asynchronous reset, active high
req  input  1  access request
we  input  1  1=write, 0=read; sampled with req
addr  input  ADDR_W  row address; sampled with req
wdata  input  COLS  write data; sampled with req
ready  output  1  controller idle, can accept a request
done  output  1  one-cycle access-complete pulse
err  output  1  one-cycle pulse with done: address out of range
rdata  output  COLS  last read data; held until next read completes
sa_out  input  real[0:COLS-1]  sense-amp outputs
rd_wr  output  real  precharge enable level to the precharge block
wl  output  real[0:ROWS-1]  wordline levels
sae  output  real  sense-amp enable level
wr_en  output  real  write-driver enable level
din_drv  output  real[0:COLS-1]  write-driver data levels

Behaviour:
- Constants: VDD=1.5, VSS=0.0, VTH=0.8. All real outputs take only VDD or VSS. sa_out[i] reads as 1 when >= VTH.
- Reset (async, immediate): state IDLE; ready=1; done=0; err=0; rdata=0; rd_wr, sae, wr_en = VSS; all wl = VSS; all din_drv = VSS. A reset mid-access aborts it with no done pulse.
- Handshake: a request is accepted on a rising edge with req=1 and ready=1. ready=1 only in IDLE. req while busy is ignored; there is no queue. we, addr and wdata are latched at acceptance.
- A cycle counter loads duration-1 on each timed-state entry and decrements to 0.
- FSM states: IDLE, PRECH, WLON, SENSE, WRITE, DONE.
  - IDLE -> PRECH on acceptance.
  - PRECH: rd_wr=VDD; all wl=VSS. Lasts PRE_CYC cycles. Then -> WLON if read, -> WRITE if write.
  - WLON (read, 1 cycle): rd_wr=VSS; wl[addr]=VDD. -> SENSE.
  - SENSE: wl[addr]=VDD; sae=VDD. Lasts SA_CYC cycles. On the edge leaving SENSE, rdata[i] <= (sa_out[i] >= VTH). -> DONE.
  - WRITE: rd_wr=VSS; wl[addr]=VDD; wr_en=VDD; din_drv[i] = wdata[i] ? VDD : VSS. Lasts WR_CYC cycles. -> DONE.
  - DONE (1 cycle): all wl, sae, wr_en, din_drv = VSS; done=1. -> IDLE.
- Out-of-range address (addr >= ROWS):
  - Sequence still runs with identical timing, but no wl is raised.
  - rdata is not updated.
  - err=1 together with done.
- Latency, counted from the acceptance edge to the edge where done rises:
  - read: PRE_CYC+1+SA_CYC
  - write: PRE_CYC+WR_CYC
- The next request can be accepted in the cycle after DONE, giving back-to-back spacing of latency+2.
- Break-before-make: wl and rd_wr are never VDD in the same cycle. sae and wr_en are never VDD in the same cycle.
- All outputs are registered or decoded from registered state; none combinationally depends on req.

Test Plan:
- Reset then idle: rst pulse -> ready=1, done=0, rdata=0, all real outputs 0.0. Also assert rst during SENSE -> outputs return to 0.0 immediately and no done pulse.
- Read, defaults, addr=5, sa_out={1.5,0,1.5,0,0,0,1.5,1.2}:
  - rd_wr=1.5 for 2 cycles, then wl[5]=1.5 for 2 cycles, with sae=1.5 in the 2nd.
  - done high 4 cycles after acceptance; rdata=8'b11000101 (bit i = sa_out[i]).
- Write, addr=2, wdata=8'hA5:
  - rd_wr=1.5 for 2 cycles, then wl[2]=1.5 and wr_en=1.5 for 2 cycles.
  - din_drv[0]=1.5, din_drv[1]=0.0, ..., din_drv[7]=1.5.
  - done 4 cycles after acceptance; rdata unchanged.
- Busy rejection: hold req=1 continuously across two reads -> second accepted exactly one cycle after done; only two done pulses.
- Out-of-range: ROWS=6, addr=7 read -> no wl ever 1.5; done and err high together at cycle 4; rdata unchanged.
- Parameter sweep: PRE_CYC=1, SA_CYC=3 read -> done at cycle 5; sae=1.5 for exactly 3 cycles; wl and rd_wr never simultaneously 1.5.
